keypad_scan_fifo: RTL and testbench
===================================

# keypad_scan_fifo

Matrix-keypad front end for the peripheral controller's keyboard read port (address 0x0). Drives the 4x4 keypad rows, samples the columns, and debounces whole-matrix snapshots. Turns each clean single-key press into a 4-bit key code and queues the codes in a small FIFO. The controller reads the FIFO head and pops it, so key presses are not lost between CPU polls.

## Interface
- SCAN_DIV, 50000: clock cycles each row is driven; must be ≥4.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-matrix scans needed before the debounced state updates; must be ≥1.
- FIFO_DEPTH, 8: key-code queue depth; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rows  out  4  row drive, active-low one-hot (driven row = 0).
- cols  in  4  column sense, active-low (pulled up; 0 = key closed on the driven row).
- rd_en  in  1  pop the FIFO head. Ignored when the FIFO is empty.
- key_data  out  8  bit7 = FIFO non-empty; bits[3:0] = head key code when non-empty, else 0; bits[6:4] = 0.
- overflow  out  1  sticky. Set when a press is dropped because the FIFO is full; cleared only by reset.

## Operation
- cols pass through a 2-flop synchronizer before any use.
- Row scan:
  - div_cnt counts 0..SCAN_DIV-1; row_idx (0..3) advances when div_cnt wraps.
  - rows = ~(1 << row_idx).
- Sampling:
  - When div_cnt = SCAN_DIV-1, the inverted synced cols are stored into snapshot[row_idx*4 +: 4].
  - Bit index = row*4 + col, and this index is the key code.
- Scan completion: the sample cycle with row_idx = 3.
  - If the new snapshot equals prev_snap, stable_cnt increments, saturating at DEBOUNCE_SCANS. Otherwise stable_cnt clears to 0.
  - prev_snap takes the new snapshot.
- Debounce update: when stable_cnt transitions to DEBOUNCE_SCANS, debounced takes the snapshot.
- Press event: raised in the same update when the new debounced value has exactly one bit set and that bit was clear in the old debounced value.
  - Code = index of that bit.
  - Multi-key states produce no event.
  - Release produces no event.
  - Going from two keys held to one key held produces no event, because that bit was already set.
- FIFO (synchronous, FIFO_DEPTH entries):
  - A press event pushes its code.
  - A push when full is dropped and sets overflow, unless rd_en pops in the same cycle. In that case both the pop and the push happen.
  - Push when empty together with rd_en: the pop is ignored and the push is accepted.
  - Count never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- key_data is registered from the post-update FIFO state.

## Timing
- Reset values:
  - rows = 4'b1110.
  - div_cnt, row_idx, snapshot, prev_snap, stable_cnt, debounced = 0.
  - FIFO empty.
  - key_data = 8'h00; overflow = 0.
- Reset mid-scan or mid-debounce discards all partial state; scanning restarts from row 0 on the first cycle after reset deasserts.
- One full scan = 4*SCAN_DIV cycles.
- A key closed for a full scan k with prior scan differing:
  - debounced updates at the end of scan k+DEBOUNCE_SCANS.
  - The FIFO push occurs on the cycle after that.
  - key_data shows {1'b1, 3'b0, code} on the following cycle.
- Pop: rd_en sampled high at edge N. key_data shows the next head, or 8'h00, after edge N+1.
- Columns settle for SCAN_DIV-1 cycles after each row change before sampling.

## Structure
- Shared package keypad_pkg:
  - KEY_CODE_W = 4.
  - ROW_IDLE = 4'b1111.
  - Row one-hot encode function.
  - Single-bit detect / priority-encode function over 16 bits.
  - FIFO_DEPTH default.
- One sub-module: key_fifo.
  - Parameterized synchronous FIFO with push/pop/full/empty/head.
  - Implements the simultaneous push/pop rules above.
- Scan, debounce and edge-detect logic stay in keypad_scan_fifo.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2.
- Reset: rows=1110, key_data=00, overflow=0. rows cycle 1110→1101→1011→0111 every 4 clocks.
- Hold key row1/col2 (code 6) for 5 scans: exactly one push, and key_data=8'h86. rd_en for one cycle: key_data=8'h00.
- Bounce: toggle the key every scan for 6 scans, then release: no push, key_data stays 00.
- Press keys 3 and 9 simultaneously: no push. Release 9, keeping 3 held: no push. Release all, then press 9 alone: push code 9.
- Nine distinct presses with no reads (FIFO_DEPTH=8): codes 1..8 queued, 9th dropped, overflow=1. Eight pops return 1..8 in order, then key_data=00.
- FIFO full, with a press event in the same cycle as rd_en: head popped, new code enqueued last, overflow unchanged. Reset during a scan: state cleared, rows=1110 on the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner and its key-code FIFO.
package keypad_pkg;

  localparam int KEY_CODE_W         = 4;
  localparam int NUM_KEYS           = 16;
  localparam int FIFO_DEPTH_DEFAULT = 8;
  localparam logic [3:0] ROW_IDLE   = 4'b1111;

  // Result of encoding a 16-bit key snapshot.
  typedef struct packed {
    logic                  single;  // exactly one key closed
    logic [KEY_CODE_W-1:0] code;    // index of the lowest closed key
  } key_hit_t;

  // Active-low one-hot row drive for row index idx.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    row_drive = ROW_IDLE ^ (4'b0001 << idx);
  endfunction

  // Priority-encode the lowest set bit and flag whether it is the only one.
  function automatic key_hit_t key_encode(input logic [NUM_KEYS-1:0] v);
    key_encode = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) key_encode.code = KEY_CODE_W'(i);
    end
    key_encode.single = (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO for key codes. A pop is ignored when empty; a push is
// accepted when full only if a pop frees an entry in the same cycle.
module key_fifo import keypad_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int W     = KEY_CODE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop, do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and occupancy values; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the empty flag masks stale entries, and resetting it would cost a reset net per bit.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// 4x4 matrix keypad front end: row scan, whole-matrix debounce, single-key
// press detection, and a key-code FIFO read through key_data / rd_en.
module keypad_scan_fifo import keypad_pkg::*; #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic       rd_en,
  output logic [7:0] key_data,
  output logic       overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS);

  logic [3:0]            cols_meta_q, cols_meta_d, cols_sync_q, cols_sync_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [1:0]            row_idx_q, row_idx_d;
  logic [NUM_KEYS-1:0]   snapshot_q, snapshot_d, new_snap;
  logic [NUM_KEYS-1:0]   prev_snap_q, prev_snap_d;
  logic [NUM_KEYS-1:0]   debounced_q, debounced_d;
  logic [STB_W-1:0]      stable_cnt_q, stable_cnt_d;
  logic                  push_q, push_d;
  logic [KEY_CODE_W-1:0] push_code_q, push_code_d;
  logic [7:0]            key_data_q, key_data_d;
  logic                  overflow_q, overflow_d;

  logic                  sample, scan_done, deb_update;
  key_hit_t              hit;
  logic [KEY_CODE_W-1:0] fifo_head;
  logic                  fifo_empty, fifo_full;

  assign sample    = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
  assign scan_done = sample && (row_idx_q == 2'd3);
  assign hit       = key_encode(new_snap);
  assign rows      = row_drive(row_idx_q);
  assign key_data  = key_data_q;
  assign overflow  = overflow_q;

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KEY_CODE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_q),
    .data_i  (push_code_q),
    .pop_i   (rd_en),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Scan, sample, debounce and press-event next-state logic.
  always_comb begin
    cols_meta_d  = cols;
    cols_sync_d  = cols_meta_q;
    div_cnt_d    = sample ? '0 : div_cnt_q + DIV_W'(1);
    row_idx_d    = sample ? row_idx_q + 2'd1 : row_idx_q;

    // Snapshot as it stands after this cycle's sample (closed key = 1).
    new_snap = snapshot_q;
    new_snap[{row_idx_q, 2'b00} +: 4] = ~cols_sync_q;
    snapshot_d = sample ? new_snap : snapshot_q;

    prev_snap_d  = prev_snap_q;
    stable_cnt_d = stable_cnt_q;
    if (scan_done) begin
      prev_snap_d = new_snap;
      if (new_snap != prev_snap_q)      stable_cnt_d = '0;
      else if (stable_cnt_q != STB_MAX) stable_cnt_d = stable_cnt_q + STB_W'(1);
    end

    // Update only on the scan that first reaches the stability threshold.
    deb_update  = scan_done && (stable_cnt_q != STB_MAX) && (stable_cnt_d == STB_MAX);
    debounced_d = deb_update ? new_snap : debounced_q;

    // A press is a lone key that was not already down in the old debounced state.
    push_d      = deb_update && hit.single && !debounced_q[hit.code];
    push_code_d = hit.code;

    // A full FIFO drops the push unless rd_en frees the head in the same cycle.
    overflow_d = overflow_q || (push_q && fifo_full && !rd_en);
    key_data_d = fifo_empty ? 8'h00 : {1'b1, 3'b000, fifo_head};
  end

  // State registers; reset discards any partial scan or debounce progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      cols_meta_q  <= 4'hF;
      cols_sync_q  <= 4'hF;
      div_cnt_q    <= '0;
      row_idx_q    <= '0;
      snapshot_q   <= '0;
      prev_snap_q  <= '0;
      stable_cnt_q <= '0;
      debounced_q  <= '0;
      push_q       <= 1'b0;
      push_code_q  <= '0;
      key_data_q   <= 8'h00;
      overflow_q   <= 1'b0;
    end else begin
      cols_meta_q  <= cols_meta_d;
      cols_sync_q  <= cols_sync_d;
      div_cnt_q    <= div_cnt_d;
      row_idx_q    <= row_idx_d;
      snapshot_q   <= snapshot_d;
      prev_snap_q  <= prev_snap_d;
      stable_cnt_q <= stable_cnt_d;
      debounced_q  <= debounced_d;
      push_q       <= push_d;
      push_code_q  <= push_code_d;
      key_data_q   <= key_data_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Self-checking bench for keypad_scan_fifo: a hand-computed vector table, a few
// directed FIFO/reset sequences, and a randomized run against a scan-level model.
module tb_keypad_scan_fifo;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 2;
  localparam int DEPTH    = 8;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_en = 1'b0;
  logic [3:0] rows, cols;
  logic [7:0] key_data;
  logic       overflow;
  logic [15:0] key_mat = '0;
  logic [7:0]  last_kd;

  int checks   = 0;
  int failures = 0;

  keypad_scan_fifo #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DS),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .rd_en    (rd_en),
    .key_data (key_data),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rows[r])
        for (int c = 0; c < 4; c++)
          if (key_mat[r*4 + c]) cols[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scan-level reference model ----------------
  logic [15:0] m_last, m_deb;
  int          m_run;       // consecutive identical scans, counting the post-reset all-open state
  logic [3:0]  m_q[$];
  logic        m_ovf, m_pend;
  logic [3:0]  m_pend_code;

  task automatic model_reset();
    m_last = '0; m_deb = '0; m_run = 1;
    m_q.delete(); m_ovf = 1'b0; m_pend = 1'b0; m_pend_code = '0;
  endtask

  // Start of a scan: the pending press (if any) and an optional pop land together.
  task automatic model_start(input logic pop);
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pend_code);
      else m_ovf = 1'b1;
      m_pend = 1'b0;
    end
  endtask

  // End of a scan with key set s held throughout.
  task automatic model_scan(input logic [15:0] s);
    if (s == m_last) m_run++;
    else m_run = 1;
    m_last = s;
    if (m_run == DS + 1) begin
      if ($countones(s) == 1 && (s & m_deb) == '0) begin
        m_pend = 1'b1;
        for (int i = 0; i < 16; i++) if (s[i]) m_pend_code = 4'(i);
      end
      m_deb = s;
    end
  endtask

  function automatic logic [7:0] model_kd();
    return (m_q.size() > 0) ? {4'h8, m_q[0]} : 8'h00;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Entered and left 1 time unit after a scan-completion edge.
  task automatic run_scan(input logic [15:0] keys, input logic pop);
    key_mat = keys;
    rd_en   = pop;
    @(posedge clk); #1 rd_en = 1'b0;
    model_start(pop);
    repeat (2) @(posedge clk);
    #1;
    check("key_data", int'(key_data), int'(model_kd()));
    check("overflow", int'(overflow), int'(m_ovf));
    last_kd = key_data;
    repeat (SCAN_CYC - 3) @(posedge clk);
    #1;
    model_scan(keys);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    rd_en = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic press(input int code);
    repeat (DS + 1) run_scan(16'h1 << code, 1'b0);
  endtask

  typedef struct {
    logic [15:0] keys;
    logic        pop;
    logic [7:0]  exp_kd;
  } step_t;
  step_t tbl[$];

  task automatic add(input logic [15:0] k, input logic p, input logic [7:0] e);
    step_t s;
    s.keys = k; s.pop = p; s.exp_kd = e;
    tbl.push_back(s);
  endtask

  initial begin
    logic [3:0]  exp_rows;
    logic [15:0] k;
    int          hold, sel;

    // Hold key 6, pop it; bounce; multi-key then lone key 9.
    for (int i = 0; i < 3; i++) add(16'h0040, 1'b0, 8'h00);
    add(16'h0040, 1'b0, 8'h86);
    add(16'h0040, 1'b0, 8'h86);
    add(16'h0000, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) add(16'h0000, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) add((i % 2 == 0) ? 16'h0040 : 16'h0000, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) add(16'h0000, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) add(16'h0208, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) add(16'h0008, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) add(16'h0000, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) add(16'h0200, 1'b0, 8'h00);
    add(16'h0200, 1'b0, 8'h89);
    add(16'h0000, 1'b1, 8'h00);

    // Reset values and row rotation.
    do_reset(3);
    check("rst_rows", int'(rows), 'he);
    check("rst_key_data", int'(key_data), 0);
    check("rst_overflow", int'(overflow), 0);
    for (int i = 0; i < SCAN_CYC; i++) begin
      exp_rows = 4'b1111 ^ (4'b0001 << (i / SCAN_DIV));
      check("row_scan", int'(rows), int'(exp_rows));
      @(posedge clk); #1;
    end
    model_scan(16'h0000);

    // Vector table.
    do_reset(2);
    foreach (tbl[i]) begin
      run_scan(tbl[i].keys, tbl[i].pop);
      check($sformatf("table[%0d]", i), int'(last_kd), int'(tbl[i].exp_kd));
    end

    // Full FIFO, next press lands together with a pop.
    do_reset(2);
    for (int c = 1; c <= 8; c++) press(c);
    press(9);
    check("full_head", int'(last_kd), 'h81);
    run_scan(16'h0200, 1'b1);
    check("simul_head", int'(last_kd), 'h82);
    check("simul_ovf", int'(overflow), 0);
    for (int e = 3; e <= 9; e++) begin
      run_scan(16'h0000, 1'b1);
      check("simul_drain", int'(last_kd), 'h80 | e);
    end
    run_scan(16'h0000, 1'b1);
    check("simul_empty", int'(last_kd), 0);

    // Nine presses with no reads: ninth dropped, overflow sticks.
    do_reset(2);
    for (int c = 1; c <= 9; c++) press(c);
    run_scan(16'h0200, 1'b0);
    check("ovf_set", int'(overflow), 1);
    check("ovf_head", int'(last_kd), 'h81);
    for (int e = 2; e <= 8; e++) begin
      run_scan(16'h0000, 1'b1);
      check("ovf_drain", int'(last_kd), 'h80 | e);
    end
    run_scan(16'h0000, 1'b1);
    check("ovf_empty", int'(last_kd), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Reset in the middle of a scan, with a queued code and partial debounce.
    do_reset(2);
    press(5);
    run_scan(16'h0020, 1'b0);
    check("pre_rst_head", int'(last_kd), 'h85);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    check("mid_rst_rows", int'(rows), 'he);
    check("mid_rst_key_data", int'(key_data), 0);
    for (int i = 0; i < DS + 2; i++) run_scan(16'h0020, 1'b0);
    check("post_rst_head", int'(last_kd), 'h85);

    // Randomized key patterns and pops against the model.
    do_reset(2);
    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 3);
      k    = '0;
      if (sel == 1 || sel == 2) k[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) begin
        k[$urandom_range(0, 7)]  = 1'b1;
        k[$urandom_range(8, 15)] = 1'b1;
      end
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) run_scan(k, ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
